// File: rtl/sig_recorder.sv
`default_nettype none
// ============================================================================
// Module   : sig_recorder
// Brief    : Triggered sample recorder with a one-shot or looped playback path.
// Revision : 1.0 - initial release
// ============================================================================
module sig_recorder #(
   parameter int A_WIDTH = 9,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               arm,
   input  logic               trig,
   input  logic               play,
   input  logic               abort,
   input  logic               loop,
   input  logic [A_WIDTH-1:0] length,
   input  logic [D_WIDTH-1:0] mic_signal,
   output logic [D_WIDTH-1:0] play_signal,
   output logic               play_valid,
   output logic               done,
   output logic [2:0]         state,
   output logic [A_WIDTH:0]   rec_len
);

   localparam logic [A_WIDTH:0] c_full = {1'b1, {A_WIDTH{1'b0}}};
   localparam logic [A_WIDTH:0] c_one  = {{A_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARMED    = 3'd1,
      S_CAPTURE  = 3'd2,
      S_READY    = 3'd3,
      S_PLAYBACK = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [A_WIDTH:0]   r_wptr, w_wptr_nxt;
   logic [A_WIDTH:0]   r_rptr, w_rptr_nxt;
   logic [A_WIDTH:0]   r_len, w_len_nxt;
   logic [A_WIDTH:0]   r_rec_len, w_rec_len_nxt;
   logic [A_WIDTH:0]   w_len_in;
   logic [A_WIDTH:0]   w_wptr_inc;
   logic [A_WIDTH-1:0] w_waddr;
   logic               w_we, w_re, w_done_nxt;
   logic               r_done;

   logic [D_WIDTH-1:0] r_mem [0:(2**A_WIDTH)-1];

   // A zero length request means the whole buffer.
   assign w_len_in   = (length == '0) ? c_full : {1'b0, length};
   assign w_wptr_inc = r_wptr + c_one;

   always_comb begin
      w_state_nxt   = r_state;
      w_wptr_nxt    = r_wptr;
      w_rptr_nxt    = r_rptr;
      w_len_nxt     = r_len;
      w_rec_len_nxt = r_rec_len;
      w_waddr       = r_wptr[A_WIDTH-1:0];
      w_we          = 1'b0;
      w_re          = 1'b0;
      w_done_nxt    = 1'b0;
      if (abort) begin
         w_state_nxt   = S_IDLE;
         w_rec_len_nxt = '0;
         w_wptr_nxt    = '0;
         w_rptr_nxt    = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (trig && en) begin
                  w_we       = 1'b1;
                  w_waddr    = '0;
                  w_wptr_nxt = c_one;
                  w_len_nxt  = w_len_in;
                  if (w_len_in == c_one) begin
                     w_state_nxt   = S_READY;
                     w_done_nxt    = 1'b1;
                     w_rec_len_nxt = w_len_in;
                  end else begin
                     w_state_nxt = S_CAPTURE;
                  end
               end
            end
            S_CAPTURE: begin
               if (en) begin
                  w_we       = 1'b1;
                  w_wptr_nxt = w_wptr_inc;
                  if (w_wptr_inc == r_len) begin
                     w_state_nxt   = S_READY;
                     w_done_nxt    = 1'b1;
                     w_rec_len_nxt = r_len;
                  end
               end
            end
            S_READY: begin
               if (play) begin
                  w_state_nxt = S_PLAYBACK;
                  w_rptr_nxt  = '0;
               end else if (arm) begin
                  w_state_nxt   = S_ARMED;
                  w_rec_len_nxt = '0;
               end
            end
            S_PLAYBACK: begin
               if (en) begin
                  w_re = 1'b1;
                  if (r_rptr == r_rec_len - c_one) begin
                     w_rptr_nxt = '0;
                     if (!loop) begin
                        w_state_nxt = S_READY;
                        w_done_nxt  = 1'b1;
                     end
                  end else begin
                     w_rptr_nxt = r_rptr + c_one;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_len     <= '0;
         r_rec_len <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_wptr    <= w_wptr_nxt;
         r_rptr    <= w_rptr_nxt;
         r_len     <= w_len_nxt;
         r_rec_len <= w_rec_len_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Storage is deliberately left out of reset; rec_len=0 hides stale data.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= mic_signal;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         play_signal <= '0;
         play_valid  <= 1'b0;
      end else begin
         play_valid <= w_re;
         if (w_re) play_signal <= r_mem[r_rptr[A_WIDTH-1:0]];
      end
   end

   assign state   = r_state;
   assign done    = r_done;
   assign rec_len = r_rec_len;

endmodule
`default_nettype wire

// File: tb/tb_sig_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_recorder
// Brief    : Vector-table and scoreboard bench for sig_recorder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig_recorder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, arm, trig, play, abort, loop;
   logic [8:0] length;
   logic [7:0] mic_signal;
   logic [7:0] play_signal;
   logic       play_valid, done;
   logic [2:0] state;
   logic [9:0] rec_len;

   sig_recorder #(.A_WIDTH(9), .D_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .arm(arm), .trig(trig), .play(play),
      .abort(abort), .loop(loop), .length(length), .mic_signal(mic_signal),
      .play_signal(play_signal), .play_valid(play_valid), .done(done),
      .state(state), .rec_len(rec_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       arm, trig, en, play, abort, lp;
      logic [8:0] len;
      logic [7:0] mic;
      logic [2:0] st;
      logic       dn;
      logic [9:0] rl;
      logic       rd;
      logic [7:0] rv;
   } vec_t;

   vec_t       vq[$];
   logic [7:0] sb_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] last_ps = 8'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic a, t, e, p, ab, lp, input logic [8:0] len,
                      input logic [7:0] mic, input logic [2:0] st, input logic dn,
                      input logic [9:0] rl, input logic rd, input logic [7:0] rv);
      vec_t v;
      v.arm = a; v.trig = t; v.en = e; v.play = p; v.abort = ab; v.lp = lp;
      v.len = len; v.mic = mic; v.st = st; v.dn = dn; v.rl = rl; v.rd = rd; v.rv = rv;
      vq.push_back(v);
   endtask

   task automatic clr();
      en = 0; arm = 0; trig = 0; play = 0; abort = 0; loop = 0;
      length = '0; mic_signal = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Playback monitor: every valid sample must match the next expected one,
   // and the output must hold its value while play_valid is low.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         last_ps = 8'd0;
      end else if (play_valid === 1'b1) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected play_valid: got sample %0d, expected none", play_signal);
         end else begin
            logic [7:0] e;
            e = sb_q.pop_front();
            if (play_signal !== e) begin
               n_err++;
               $display("FAIL play sample: got %0d, expected %0d", play_signal, e);
            end
         end
         last_ps = play_signal;
      end else begin
         n_cmp++;
         if (play_signal !== last_ps) begin
            n_err++;
            $display("FAIL play_signal hold: got %0d, expected %0d", play_signal, last_ps);
         end
      end
   end

   initial begin
      clr();
      rst = 1'b0;
      // arm trig en play abort lp len mic | st dn rl | rd rv
      add(1,0,0,0,0,0, 0,  0, 1,0,0, 0,0);
      add(0,1,1,0,0,0, 4, 10, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 4, 11, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 9, 12, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 4, 13, 3,1,4, 0,0);
      add(0,0,0,1,0,0, 0,  0, 4,0,4, 0,0);
      add(0,0,1,0,0,0, 0,  0, 4,0,4, 1,10);
      add(0,0,1,0,0,0, 0,  0, 4,0,4, 1,11);
      add(0,0,1,0,0,0, 0,  0, 4,0,4, 1,12);
      add(0,0,1,0,0,0, 0,  0, 3,1,4, 1,13);
      add(0,0,0,0,0,0, 0,  0, 3,0,4, 0,0);
      // en toggling, latched length, ignored arm/play during capture
      add(1,0,0,0,0,0, 0,  0, 1,0,0, 0,0);
      add(0,1,0,0,0,0, 3, 99, 1,0,0, 0,0);
      add(0,1,1,0,0,0, 3, 20, 2,0,0, 0,0);
      add(1,0,0,1,0,0, 1, 77, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 1, 21, 2,0,0, 0,0);
      add(0,0,0,0,0,0, 7, 55, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 1, 22, 3,1,3, 0,0);
      add(1,0,0,1,0,0, 0,  0, 4,0,3, 0,0);
      add(0,0,1,0,0,0, 0,  0, 4,0,3, 1,20);
      add(0,0,0,0,0,0, 0,  0, 4,0,3, 0,0);
      add(0,0,1,0,0,0, 0,  0, 4,0,3, 1,21);
      add(0,0,0,0,0,0, 0,  0, 4,0,3, 0,0);
      add(0,0,1,0,0,0, 0,  0, 3,1,3, 1,22);
      add(0,0,0,0,0,0, 0,  0, 3,0,3, 0,0);
      // single-sample record completes on the trigger cycle
      add(1,0,0,0,0,0, 0,  0, 1,0,0, 0,0);
      add(0,1,1,0,0,0, 1, 42, 3,1,1, 0,0);
      add(0,0,0,1,0,0, 0,  0, 4,0,1, 0,0);
      add(0,0,1,0,0,0, 0,  0, 3,1,1, 1,42);
      // looped playback, then loop dropped
      add(1,0,0,0,0,0, 0,  0, 1,0,0, 0,0);
      add(0,1,1,0,0,0, 3,  5, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 3,  6, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 3,  7, 3,1,3, 0,0);
      add(0,0,0,1,0,1, 0,  0, 4,0,3, 0,0);
      add(0,0,1,0,0,1, 0,  0, 4,0,3, 1,5);
      add(0,0,1,0,0,1, 0,  0, 4,0,3, 1,6);
      add(0,0,1,0,0,1, 0,  0, 4,0,3, 1,7);
      add(0,0,1,0,0,1, 0,  0, 4,0,3, 1,5);
      add(0,0,1,0,0,1, 0,  0, 4,0,3, 1,6);
      add(0,0,1,0,0,1, 0,  0, 4,0,3, 1,7);
      add(0,0,1,0,0,0, 0,  0, 4,0,3, 1,5);
      add(0,0,1,0,0,0, 0,  0, 4,0,3, 1,6);
      add(0,0,1,0,0,0, 0,  0, 3,1,3, 1,7);
      // abort during playback, then during capture
      add(0,0,0,1,0,0, 0,  0, 4,0,3, 0,0);
      add(0,0,1,0,0,0, 0,  0, 4,0,3, 1,5);
      add(0,0,1,0,1,0, 0,  0, 0,0,0, 0,0);
      add(0,1,1,1,0,0, 2,  9, 0,0,0, 0,0);
      add(1,0,0,0,0,0, 0,  0, 1,0,0, 0,0);
      add(0,1,1,0,0,0, 5,  1, 2,0,0, 0,0);
      add(0,0,1,0,0,0, 5,  2, 2,0,0, 0,0);
      add(1,0,1,1,1,0, 5,  3, 0,0,0, 0,0);
      add(0,0,0,0,0,0, 0,  0, 0,0,0, 0,0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset state", state, 0);
      chk("reset play_valid", play_valid, 0);
      chk("reset play_signal", play_signal, 0);
      chk("reset done", done, 0);
      chk("reset rec_len", rec_len, 0);
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         arm = vq[i].arm; trig = vq[i].trig; en = vq[i].en; play = vq[i].play;
         abort = vq[i].abort; loop = vq[i].lp; length = vq[i].len; mic_signal = vq[i].mic;
         if (vq[i].rd) sb_q.push_back(vq[i].rv);
         step();
         chk($sformatf("row%0d state", i), state, vq[i].st);
         chk($sformatf("row%0d done", i), done, vq[i].dn);
         chk($sformatf("row%0d rec_len", i), rec_len, vq[i].rl);
      end
      clr();
      step();
      chk("table samples drained", sb_q.size(), 0);

      // full-depth record
      arm = 1; step(); arm = 0;
      for (int i = 0; i < 512; i++) begin
         trig = (i == 0); en = 1; length = 9'd0; mic_signal = 8'(i);
         step();
         if (i == 510) chk("full depth before last write state", state, 2);
      end
      clr();
      chk("full depth capture state", state, 3);
      chk("full depth capture done", done, 1);
      chk("full depth rec_len", rec_len, 512);
      play = 1; step(); play = 0;
      for (int i = 0; i < 512; i++) begin
         en = 1; sb_q.push_back(8'(i));
         step();
         if (i == 510) chk("full depth before last read state", state, 4);
      end
      en = 0;
      chk("full depth playback state", state, 3);
      chk("full depth playback done", done, 1);
      step();
      chk("full depth samples drained", sb_q.size(), 0);

      // asynchronous reset in the middle of playback
      arm = 1; step(); arm = 0;
      trig = 1; en = 1; length = 9'd3; mic_signal = 8'h51; step(); trig = 0;
      mic_signal = 8'h52; step();
      mic_signal = 8'h53; step();
      clr();
      play = 1; step(); play = 0;
      en = 1; sb_q.push_back(8'h51); step();
      @(posedge clk);
      #2;
      chk("pre-reset play_valid", play_valid, 1);
      chk("pre-reset play_signal", play_signal, 8'h52);
      rst = 1'b0;
      #1;
      chk("async reset play_valid", play_valid, 0);
      chk("async reset play_signal", play_signal, 0);
      chk("async reset state", state, 0);
      chk("async reset rec_len", rec_len, 0);
      chk("async reset done", done, 0);
      clr();
      @(posedge clk);
      #3 rst = 1'b1;
      step();
      chk("post-reset state", state, 0);
      for (int i = 0; i < 3; i++) begin
         play = 1; en = 1; step();
         chk($sformatf("post-reset play ignored %0d", i), state, 0);
      end
      clr();
      chk("post-reset rec_len", rec_len, 0);
      arm = 1; step(); arm = 0;
      trig = 1; en = 1; length = 9'd2; mic_signal = 8'h61; step(); trig = 0;
      mic_signal = 8'h62; step();
      clr();
      chk("recapture rec_len", rec_len, 2);
      play = 1; step(); play = 0;
      en = 1; sb_q.push_back(8'h61); step();
      sb_q.push_back(8'h62); step();
      en = 0;
      chk("recapture playback state", state, 3);
      chk("recapture playback done", done, 1);
      step();
      step();
      chk("final samples drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sig_recorder.md
SIG_RECORDER -- requirements
Module: sig_recorder

Interface
REQ-001 Parameter A_WIDTH, default 9, SHALL set the buffer address width; depth is 2**A_WIDTH samples.
REQ-002 Parameter D_WIDTH, default 8, SHALL set the sample width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the sample strobe; capture and playback advance only on cycles with en=1.
REQ-006 arm  input  1  SHALL be the pulse that arms the recorder for a trigger.
REQ-007 trig  input  1  SHALL be the capture-start trigger, sampled only while armed.
REQ-008 play  input  1  SHALL be the pulse that starts playback of the captured record.
REQ-009 abort  input  1  SHALL be the pulse that cancels any activity and returns to IDLE.
REQ-010 loop  input  1  SHALL, when 1, make playback restart at address 0 instead of ending.
REQ-011 length  input  A_WIDTH  SHALL be the requested capture length; 0 means 2**A_WIDTH.
REQ-012 mic_signal  input  D_WIDTH  SHALL be the sample written during capture.
REQ-013 play_signal  output  D_WIDTH  SHALL be the sample read back during playback.
REQ-014 play_valid  output  1  SHALL be high for exactly the cycles where play_signal holds a new playback sample.
REQ-015 done  output  1  SHALL pulse one cycle at end of capture and at end of non-looped playback.
REQ-016 state  output  3  SHALL encode IDLE=0, ARMED=1, CAPTURE=2, READY=3, PLAYBACK=4.
REQ-017 rec_len  output  A_WIDTH+1  SHALL hold the number of samples in the stored record (0 when none).

Function
REQ-018 Storage SHALL be an internal 2**A_WIDTH x D_WIDTH memory with one write port and one registered read port (1-cycle read latency).
REQ-019 IDLE: arm=1 -> ARMED; all other inputs ignored.
REQ-020 ARMED: trig=1 and en=1 in the same cycle -> CAPTURE; that cycle's mic_signal is written at address 0, write pointer becomes 1; trig with en=0 ignored.
REQ-021 The capture length SHALL be latched from length at the trigger cycle; later changes to length SHALL have no effect on that capture.
REQ-022 CAPTURE: each en=1 cycle writes mic_signal at the write pointer and increments it; en=0 stalls with no write.
REQ-023 When the write count reaches the latched length, the FSM SHALL go to READY, pulse done for that cycle, and set rec_len to the latched length (2**A_WIDTH when 0).
REQ-024 Capturing length=1 SHALL complete on the trigger cycle itself (ARMED -> READY directly, done pulsed).
REQ-025 READY: play=1 -> PLAYBACK with read pointer 0; arm=1 -> ARMED and rec_len cleared to 0; play and arm together -> play wins.
REQ-026 PLAYBACK: each en=1 cycle issues a read at the read pointer; the data SHALL appear on play_signal with play_valid=1 exactly one cycle later.
REQ-027 After reading address rec_len-1: loop=0 -> READY, done pulses in the cycle the last sample is valid; loop=1 -> read pointer wraps to 0, no done, state stays PLAYBACK.
REQ-028 Pointer arithmetic SHALL be A_WIDTH+1 bits internally so a full-depth record (2**A_WIDTH) terminates correctly; memory address uses the low A_WIDTH bits.
REQ-029 play_signal SHALL hold its last value when play_valid=0.
REQ-030 abort=1 SHALL have priority over every other input in every state: -> IDLE next cycle, rec_len cleared, no write that cycle, any in-flight read SHALL NOT assert play_valid.
REQ-031 arm, play, trig SHALL be ignored in states where REQ-019..REQ-027 give them no meaning (e.g. arm during CAPTURE, play during CAPTURE).

Reset
REQ-032 rst=0 SHALL asynchronously force state=IDLE, play_signal=0, play_valid=0, done=0, rec_len=0, and all pointers to 0.
REQ-033 Memory contents SHALL NOT be reset; a record is unreachable after reset because rec_len=0.
REQ-034 Reset asserted mid-capture or mid-playback SHALL take effect without waiting for a clock edge; the first edge after release SHALL see IDLE.

Verification
REQ-035 length=4, en=1 always, arm then trig, mic_signal=10,11,12,13 -> done pulse on 4th write, state=READY, rec_len=4; play -> play_valid 4 cycles carrying 10,11,12,13, done on the 13 cycle, state=READY.
REQ-036 en toggling 1,0,1,0 during capture and playback -> writes/reads only on en=1 cycles; playback sequence identical, play_valid never high two cycles after an en=0 read slot.
REQ-037 length=0 (full depth 512), ramp mic_signal 0..511 mod 256 -> rec_len=512, playback returns 512 samples in order, pointer wrap correct.
REQ-038 loop=1, rec_len=3 with samples 5,6,7 -> play_signal 5,6,7,5,6,7,... with no done; drop loop -> ends after next 7 with done.
REQ-039 abort in mid-capture and in mid-playback -> IDLE next cycle, rec_len=0, no further play_valid; arm in CAPTURE and play in CAPTURE ignored.
REQ-040 rst=0 asserted between clock edges during PLAYBACK -> outputs zero immediately; after release, play ignored until a new capture completes.
